// File: rtl/unlock_ctrl.sv
// unlock_ctrl: keypad passcode sequencer owning the lock state.
// Collects accepted digits (0..9) into a shift buffer and compares a full
// entry against the stored code. It counts consecutive failures and enforces
// a timed lockout. While unlocked it supports re-lock and passcode change.
//
// Optional feature macro: LOCKOUT_ESC_EN
//   defined   : lockout duration escalates LOCKOUT_CMAX << lo_lvl (lo_lvl 0..3)
//   undefined : lockout duration is always LOCKOUT_CMAX
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   key_vld/key_val  one-cycle digit strobe and digit value
//   key_clr          abandon the current entry
//   lock_req         re-lock request
//   set_req          start a passcode change (while unlocked)
//   lock, led_lck    1 = locked (led_lck mirrors lock)
//   lockout          1 = lockout timer running
//   fail_cnt         consecutive failed attempts
//   ent_cnt          digits collected in the current entry
//   tr_ok / tr_bad   one-cycle result pulses

`ifndef C_MS
// Fallback when the cycle-count header is absent: assumes a 1 MHz clk.
`define C_MS(ms) ((ms) * 1000)
`endif

module unlock_ctrl #(
    parameter int unsigned        NDIG         = 4,
    parameter logic [NDIG*4-1:0]  DEF_CODE     = 16'h1234,
    parameter int unsigned        MAX_FAIL     = 3,
    parameter int unsigned        LOCKOUT_CMAX = `C_MS(10000),
    parameter int unsigned        ENT_CMAX     = `C_MS(5000)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_vld,
    input  logic [3:0] key_val,
    input  logic       key_clr,
    input  logic       lock_req,
    input  logic       set_req,
    output logic       lock,
    output logic       led_lck,
    output logic       lockout,
    output logic [2:0] fail_cnt,
    output logic [3:0] ent_cnt,
    output logic       tr_ok,
    output logic       tr_bad
);

    localparam int unsigned BW = NDIG * 4;
`ifdef LOCKOUT_ESC_EN
    localparam int unsigned LO_MAX = LOCKOUT_CMAX * 8;
`else
    localparam int unsigned LO_MAX = LOCKOUT_CMAX;
`endif
    localparam int unsigned TMR_MAX = (LO_MAX > ENT_CMAX) ? LO_MAX : ENT_CMAX;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_LOCKED,
        S_ENTRY,
        S_CHECK,
        S_LOCKOUT,
        S_UNLOCKED,
        S_SETCODE,
        S_SETCOMMIT
    } state_t;

    state_t         state_q, state_d;
    logic           lock_q, lock_d;
    logic           lockout_q, lockout_d;
    logic [2:0]     fail_q, fail_d;
    logic [3:0]     ent_q, ent_d;
    logic           tr_ok_q, tr_ok_d;
    logic           tr_bad_q, tr_bad_d;
    logic [BW-1:0]  code_q, code_d;
    logic [BW-1:0]  buf_q, buf_d;
    logic [TW-1:0]  tmr_q, tmr_d;
`ifdef LOCKOUT_ESC_EN
    logic [1:0]     lo_lvl_q, lo_lvl_d;
`endif

    // Decoded conditions shared by next-state and output logic
    logic          dig_acc, take_dig, last_dig, ent_to, lo_done, match, fail_max;
    logic          counting;
    logic [2:0]    fail_inc;
    logic [TW-1:0] lo_dur;

    assign dig_acc  = key_vld && (key_val <= 4'd9);
    assign last_dig = (ent_q == 4'(NDIG - 1));
    assign ent_to   = (tmr_q == TW'(ENT_CMAX - 1));
`ifdef LOCKOUT_ESC_EN
    assign lo_dur   = TW'(LOCKOUT_CMAX) << lo_lvl_q;
`else
    assign lo_dur   = TW'(LOCKOUT_CMAX);
`endif
    assign lo_done  = (tmr_q == (lo_dur - TW'(1)));
    assign match    = (buf_q == code_q);
    assign fail_inc = fail_q + 3'd1;
    assign fail_max = (fail_inc == 3'(MAX_FAIL));
    assign counting = (state_q == S_ENTRY) || (state_q == S_SETCODE) ||
                      (state_q == S_LOCKOUT);

    // A digit is consumed only where no higher-priority request wins
    assign take_dig = dig_acc &&
                      ((state_q == S_LOCKED) ||
                       ((state_q == S_ENTRY) && !key_clr) ||
                       ((state_q == S_SETCODE) && !lock_req && !key_clr));

    // State register and registered outputs/datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_LOCKED;
            lock_q    <= 1'b1;
            lockout_q <= 1'b0;
            fail_q    <= '0;
            ent_q     <= '0;
            tr_ok_q   <= 1'b0;
            tr_bad_q  <= 1'b0;
            code_q    <= DEF_CODE;
            buf_q     <= '0;
            tmr_q     <= '0;
`ifdef LOCKOUT_ESC_EN
            lo_lvl_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            lockout_q <= lockout_d;
            fail_q    <= fail_d;
            ent_q     <= ent_d;
            tr_ok_q   <= tr_ok_d;
            tr_bad_q  <= tr_bad_d;
            code_q    <= code_d;
            buf_q     <= buf_d;
            tmr_q     <= tmr_d;
`ifdef LOCKOUT_ESC_EN
            lo_lvl_q  <= lo_lvl_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOCKED: begin
                if (take_dig) state_d = last_dig ? S_CHECK : S_ENTRY;
            end
            S_ENTRY: begin
                if (key_clr)       state_d = S_LOCKED;
                else if (take_dig) state_d = last_dig ? S_CHECK : S_ENTRY;
                else if (ent_to)   state_d = S_LOCKED;
            end
            S_CHECK: begin
                if (match)         state_d = S_UNLOCKED;
                else if (fail_max) state_d = S_LOCKOUT;
                else               state_d = S_LOCKED;
            end
            S_LOCKOUT: begin
                if (lo_done) state_d = S_LOCKED;
            end
            S_UNLOCKED: begin
                if (lock_req)     state_d = S_LOCKED;
                else if (set_req) state_d = S_SETCODE;
            end
            S_SETCODE: begin
                if (lock_req)      state_d = S_LOCKED;
                else if (key_clr)  state_d = S_UNLOCKED;
                else if (take_dig) state_d = last_dig ? S_SETCOMMIT : S_SETCODE;
                else if (ent_to)   state_d = S_UNLOCKED;
            end
            S_SETCOMMIT: state_d = S_UNLOCKED;
            default:     state_d = S_LOCKED;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        lock_d    = lock_q;
        lockout_d = lockout_q;
        fail_d    = fail_q;
        ent_d     = ent_q;
        tr_ok_d   = 1'b0;
        tr_bad_d  = 1'b0;
        code_d    = code_q;
        buf_d     = buf_q;
`ifdef LOCKOUT_ESC_EN
        lo_lvl_d  = lo_lvl_q;
`endif

        // New digit enters at the LS nibble
        if (take_dig) begin
            buf_d = (buf_q << 4) | BW'(key_val);
            ent_d = ent_q + 4'd1;
        end else if (state_d != state_q) begin
            ent_d = '0;
        end

        // One timer for entry idle and lockout; restarts on any state change or digit
        if ((state_d != state_q) || take_dig || !counting) tmr_d = '0;
        else                                               tmr_d = tmr_q + TW'(1);

        case (state_q)
            S_CHECK: begin
                if (match) begin
                    lock_d  = 1'b0;
                    fail_d  = '0;
                    tr_ok_d = 1'b1;
`ifdef LOCKOUT_ESC_EN
                    lo_lvl_d = '0;
`endif
                end else begin
                    fail_d   = fail_inc;
                    tr_bad_d = 1'b1;
                    if (fail_max) lockout_d = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (lo_done) begin
                    lockout_d = 1'b0;
                    fail_d    = '0;
`ifdef LOCKOUT_ESC_EN
                    if (lo_lvl_q != 2'd3) lo_lvl_d = lo_lvl_q + 2'd1;
`endif
                end
            end
            S_UNLOCKED, S_SETCODE: begin
                if (lock_req) lock_d = 1'b1;
            end
            S_SETCOMMIT: begin
                code_d  = buf_q;
                tr_ok_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign lock     = lock_q;
    assign led_lck  = lock_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;
    assign ent_cnt  = ent_q;
    assign tr_ok    = tr_ok_q;
    assign tr_bad   = tr_bad_q;

endmodule

// File: tb/tb_unlock_ctrl.sv
// Directed bench for unlock_ctrl with a result scoreboard.
module tb_unlock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_vld, key_clr, lock_req, set_req;
    logic [3:0] key_val;
    logic       lock, led_lck, lockout, tr_ok, tr_bad;
    logic [2:0] fail_cnt;
    logic [3:0] ent_cnt;

    unlock_ctrl #(
        .NDIG(4), .DEF_CODE(16'h1234), .MAX_FAIL(3),
        .LOCKOUT_CMAX(20), .ENT_CMAX(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_vld(key_vld), .key_val(key_val), .key_clr(key_clr),
        .lock_req(lock_req), .set_req(set_req),
        .lock(lock), .led_lck(led_lck), .lockout(lockout),
        .fail_cnt(fail_cnt), .ent_cnt(ent_cnt),
        .tr_ok(tr_ok), .tr_bad(tr_bad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ok;
        logic       bad;
        logic       lk;
        logic       lo;
        logic [2:0] fc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   res_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and end just after a falling edge
    task automatic press(input logic [3:0] d);
        key_vld = 1'b1; key_val = d;
        @(negedge clk);
        key_vld = 1'b0;
    endtask

    task automatic pulse_lock();
        lock_req = 1'b1; @(negedge clk); lock_req = 1'b0;
    endtask

    task automatic pulse_set();
        set_req = 1'b1; @(negedge clk); set_req = 1'b0;
    endtask

    task automatic pulse_clr();
        key_clr = 1'b1; @(negedge clk); key_clr = 1'b0;
    endtask

    task automatic expect_result(input logic ok, input logic lk, input logic lo, input logic [2:0] fc);
        exp_t e;
        e.ok = ok; e.bad = ~ok; e.lk = lk; e.lo = lo; e.fc = fc;
        sb.push_back(e);
    endtask

    // Result is due one edge after the last digit; then both pulses must drop
    task automatic check_result(input string tag);
        exp_t e;
        @(negedge clk);
        res_cyc = cyc;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_tr_ok"},   32'(tr_ok),    32'(e.ok));
            chk({tag, "_tr_bad"},  32'(tr_bad),   32'(e.bad));
            chk({tag, "_lock"},    32'(lock),     32'(e.lk));
            chk({tag, "_led"},     32'(led_lck),  32'(e.lk));
            chk({tag, "_lockout"}, 32'(lockout),  32'(e.lo));
            chk({tag, "_fail"},    32'(fail_cnt), 32'(e.fc));
            chk({tag, "_ent"},     32'(ent_cnt),  32'd0);
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'({tr_ok, tr_bad}), 32'd0);
    endtask

    task automatic enter_code(input string tag, input logic [15:0] code,
                              input logic ok, input logic lk, input logic lo,
                              input logic [2:0] fc);
        expect_result(ok, lk, lo, fc);
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
        check_result(tag);
    endtask

    // Measure lockout length from the result edge, bounded
    task automatic wait_lockout(input string tag, input int exp_len);
        for (int i = 0; i < 100 && lockout === 1'b1; i++) @(negedge clk);
        chk({tag, "_len"},  32'(cyc - res_cyc), 32'(exp_len));
        chk({tag, "_fail"}, 32'(fail_cnt), 32'd0);
    endtask

    int lo2_len;

    initial begin
`ifdef LOCKOUT_ESC_EN
        lo2_len = 40;
`else
        lo2_len = 20;
`endif
        rst_n = 1'b0; key_vld = 1'b0; key_val = 4'd0;
        key_clr = 1'b0; lock_req = 1'b0; set_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lock",    32'(lock),     32'd1);
        chk("rst_led",     32'(led_lck),  32'd1);
        chk("rst_lockout", 32'(lockout),  32'd0);
        chk("rst_fail",    32'(fail_cnt), 32'd0);
        chk("rst_ent",     32'(ent_cnt),  32'd0);
        chk("rst_pulses",  32'({tr_ok, tr_bad}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: default code unlocks, ent_cnt tracks digits
        expect_result(1'b1, 1'b0, 1'b0, 3'd0);
        press(4'd1); press(4'd2);
        chk("t1_ent2", 32'(ent_cnt), 32'd2);
        press(4'd3); press(4'd4);
        check_result("t1");
        pulse_lock();
        chk("t1_relock", 32'(lock), 32'd1);

        // 2: three failures -> lockout; digits ignored; exact duration
        enter_code("t2_bad1", 16'h1235, 1'b0, 1'b1, 1'b0, 3'd1);
        enter_code("t2_bad2", 16'h1235, 1'b0, 1'b1, 1'b0, 3'd2);
        enter_code("t2_bad3", 16'h1235, 1'b0, 1'b1, 1'b1, 3'd3);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("t2_lo_ent",  32'(ent_cnt), 32'd0);
        chk("t2_lo_lock", 32'(lock),    32'd1);
        chk("t2_lo_pul",  32'({tr_ok, tr_bad}), 32'd0);
        wait_lockout("t2_lo1", 20);
        enter_code("t2_bad4", 16'h1235, 1'b0, 1'b1, 1'b0, 3'd1);
        enter_code("t2_bad5", 16'h1235, 1'b0, 1'b1, 1'b0, 3'd2);
        enter_code("t2_bad6", 16'h1235, 1'b0, 1'b1, 1'b1, 3'd3);
        wait_lockout("t2_lo2", lo2_len);
        enter_code("t2_ok", 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0);

        // 3: change code to 9876, relock, old code fails, new unlocks
        pulse_set();
        enter_code("t3_set", 16'h9876, 1'b1, 1'b0, 1'b0, 3'd0);
        pulse_lock();
        chk("t3_relock", 32'(lock), 32'd1);
        enter_code("t3_old", 16'h1234, 1'b0, 1'b1, 1'b0, 3'd1);
        enter_code("t3_new", 16'h9876, 1'b1, 1'b0, 1'b0, 3'd0);
        pulse_lock();

        // 6: reset mid-entry restores default code and clears counters
        enter_code("t6_bad", 16'h1111, 1'b0, 1'b1, 1'b0, 3'd1);
        press(4'd9); press(4'd8);
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        chk("t6_lock", 32'(lock),     32'd1);
        chk("t6_ent",  32'(ent_cnt),  32'd0);
        chk("t6_fail", 32'(fail_cnt), 32'd0);
        enter_code("t6_def", 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0);
        pulse_lock();

        // 4: idle timeout boundary, key_clr, non-digit key
        press(4'd1); press(4'd2);
        repeat (9) @(negedge clk);
        chk("t4_idle9",  32'(ent_cnt), 32'd2);
        @(negedge clk);
        chk("t4_idle10", 32'(ent_cnt), 32'd0);
        chk("t4_fail",   32'(fail_cnt), 32'd0);
        press(4'd1);
        pulse_clr();
        chk("t4_clr", 32'(ent_cnt), 32'd0);
        press(4'hC);
        chk("t4_hexC", 32'(ent_cnt), 32'd0);
        enter_code("t4_ok", 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0);

        // 5: lock_req beats a simultaneous digit in SETCODE; code kept
        pulse_set();
        press(4'd5); press(4'd5); press(4'd5);
        chk("t5_ent3", 32'(ent_cnt), 32'd3);
        lock_req = 1'b1; key_vld = 1'b1; key_val = 4'd5;
        @(negedge clk);
        lock_req = 1'b0; key_vld = 1'b0;
        chk("t5_lock", 32'(lock), 32'd1);
        chk("t5_ent",  32'(ent_cnt), 32'd0);
        chk("t5_pul",  32'({tr_ok, tr_bad}), 32'd0);
        enter_code("t5_ok", 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
